// File: rtl/ulpi_cmd_arbiter.sv
// Round-robin arbiter sharing the ULPI link command port between NUM_REQ requesters.
// Optional per-phase wait timeout is enabled by defining ULPI_CMD_TIMEOUT_EN.
module ulpi_cmd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [7:0]             link_cmd,
    output logic                   link_cmd_strobe,
    input  logic                   link_cmd_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ulpi_cmd_arbiter: parameter out of range");
    end

    state_t               state_r;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 noop_r;
    logic [IDX_W-1:0]     sel_idx_s;
    logic                 sel_valid_s;
    logic [7:0]           sel_cmd_s;
    logic [IDX_W:0]       cand_s;
    logic                 hit_s;

`ifdef ULPI_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     cnt_r;
    logic                 expired_s;
    assign expired_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        next_idx = (i == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : i + IDX_W'(1);
    endfunction

    // Pick the first active request at or after the round-robin pointer, wrapping.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = {IDX_W{1'b0}};
        cand_s      = {(IDX_W+1){1'b0}};
        hit_s       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s      = {1'b0, ptr_r} + (IDX_W+1)'(k);
            cand_s      = (cand_s >= (IDX_W+1)'(NUM_REQ)) ? cand_s - (IDX_W+1)'(NUM_REQ) : cand_s;
            hit_s       = !sel_valid_s && req[cand_s[IDX_W-1:0]];
            sel_idx_s   = hit_s ? cand_s[IDX_W-1:0] : sel_idx_s;
            sel_valid_s = sel_valid_s | hit_s;
        end
        sel_cmd_s = req_cmd[{sel_idx_s, 3'b000} +: 8];
    end

    // Command FSM; every output is a register, pulses default low each cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            ptr_r           <= {IDX_W{1'b0}};
            idx_r           <= {IDX_W{1'b0}};
            noop_r          <= 1'b0;
            grant           <= {NUM_REQ{1'b0}};
            done            <= {NUM_REQ{1'b0}};
            err             <= {NUM_REQ{1'b0}};
            link_cmd        <= 8'h00;
            link_cmd_strobe <= 1'b0;
`ifdef ULPI_CMD_TIMEOUT_EN
            cnt_r           <= {CNT_W{1'b0}};
`endif
        end else begin
            grant           <= {NUM_REQ{1'b0}};
            done            <= {NUM_REQ{1'b0}};
            err             <= {NUM_REQ{1'b0}};
            link_cmd_strobe <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sel_valid_s && !link_cmd_busy) begin
                        idx_r           <= sel_idx_s;
                        link_cmd        <= sel_cmd_s;
                        noop_r          <= (sel_cmd_s == 8'h00);
                        grant           <= onehot(sel_idx_s);
                        // A NOOP byte never reaches the link: finish it at grant time.
                        link_cmd_strobe <= (sel_cmd_s != 8'h00);
                        done            <= (sel_cmd_s == 8'h00) ? onehot(sel_idx_s) : {NUM_REQ{1'b0}};
                        state_r         <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    ptr_r   <= next_idx(idx_r);
                    state_r <= noop_r ? ST_IDLE : ST_WAIT_ACK;
`ifdef ULPI_CMD_TIMEOUT_EN
                    cnt_r   <= {CNT_W{1'b0}};
`endif
                end
                ST_WAIT_ACK: begin
                    if (link_cmd_busy) begin
                        state_r <= ST_WAIT_DONE;
`ifdef ULPI_CMD_TIMEOUT_EN
                        cnt_r   <= {CNT_W{1'b0}};
                    end else if (expired_s) begin
                        done    <= onehot(idx_r);
                        err     <= onehot(idx_r);
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
`else
                    end else begin
                        state_r <= ST_WAIT_ACK;
`endif
                    end
                end
                ST_WAIT_DONE: begin
                    if (!link_cmd_busy) begin
                        done    <= onehot(idx_r);
                        state_r <= ST_IDLE;
`ifdef ULPI_CMD_TIMEOUT_EN
                    end else if (expired_s) begin
                        done    <= onehot(idx_r);
                        err     <= onehot(idx_r);
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
`else
                    end else begin
                        state_r <= ST_WAIT_DONE;
`endif
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ulpi_cmd_arbiter.sv
// Self-checking bench for ulpi_cmd_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level round-robin model with a scripted link.
module tb_ulpi_cmd_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_cmd;
    logic [N-1:0]   grant, done, err;
    logic [7:0]     link_cmd;
    logic           link_cmd_strobe;
    logic           link_cmd_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;

    ulpi_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_cmd(req_cmd),
        .grant(grant), .done(done), .err(err), .link_cmd(link_cmd),
        .link_cmd_strobe(link_cmd_strobe), .link_cmd_busy(link_cmd_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] oh(input int i);
        oh = '0;
        oh[i] = 1'b1;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; req = '0; req_cmd = '0; link_cmd_busy = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({grant, done, err, link_cmd_strobe} !== '0) begin
            n_bad++;
            $display("FAIL reset_pulses got %b/%b/%b/%b want all 0", grant, done, err, link_cmd_strobe);
        end
        n_cmp++;
        if (link_cmd !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_link_cmd got %h want 00", link_cmd);
        end
        reset_n = 1'b1;
        m_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int  exp;
        bit  seen, bad_strobe;
        req = '1;
        for (int i = 0; i < N; i++) req_cmd[8*i +: 8] = 8'(8'h81 + i);
        for (int s = 0; s < 5; s++) begin
            exp  = m_ptr;
            seen = 1'b0;
            for (int w = 0; w < 20 && !seen; w++) begin
                @(negedge clk);
                if (grant != '0) seen = 1'b1;
            end
            n_cmp++;
            if (!seen || grant !== oh(exp)) begin
                n_bad++;
                $display("FAIL rr_grant[%0d] got %b want %b", s, grant, oh(exp));
            end
            n_cmp++;
            if (link_cmd !== 8'(8'h81 + exp) || link_cmd_strobe !== 1'b1) begin
                n_bad++;
                $display("FAIL rr_cmd[%0d] got %h/%b want %h/1", s, link_cmd, link_cmd_strobe, 8'(8'h81 + exp));
            end
            m_ptr = (exp + 1) % N;
            if (s == 4) req = '0;
            link_cmd_busy = 1'b1;
            bad_strobe = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (link_cmd_strobe !== 1'b0) bad_strobe = 1'b1;
            end
            link_cmd_busy = 1'b0;
            @(negedge clk);
            if (link_cmd_strobe !== 1'b0) bad_strobe = 1'b1;
            n_cmp++;
            if (done !== oh(exp) || bad_strobe) begin
                n_bad++;
                $display("FAIL rr_done[%0d] got %b strobe_in_busy=%0d want %b", s, done, bad_strobe, oh(exp));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        bit early;
        req = 4'b0001; req_cmd = '0; req_cmd[7:0] = 8'h84;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001 || link_cmd_strobe !== 1'b1 || link_cmd !== 8'h84) begin
            n_bad++;
            $display("FAIL single_issue got g=%b s=%b c=%h want 0001/1/84", grant, link_cmd_strobe, link_cmd);
        end
        req = '0;
        link_cmd_busy = 1'b1;
        early = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== '0 || link_cmd_strobe !== 1'b0 || grant !== '0) early = 1'b1;
        end
        link_cmd_busy = 1'b0;
        n_cmp++;
        if (early) begin
            n_bad++;
            $display("FAIL single_quiet got early pulse want none");
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 4'b0001 || err !== '0) begin
            n_bad++;
            $display("FAIL single_done got %b err=%b want 0001 err=0000", done, err);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== '0) begin
            n_bad++;
            $display("FAIL single_done_width got %b want 0000", done);
        end
        m_ptr = 1;
    endtask

    task automatic test_busy_block();
        bit early;
        link_cmd_busy = 1'b1;
        req = 4'b0100; req_cmd = '0; req_cmd[23:16] = 8'h5A;
        early = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (link_cmd_strobe !== 1'b0 || grant !== '0) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_bad++;
            $display("FAIL busy_block got strobe while busy want none");
        end
        link_cmd_busy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0100 || link_cmd_strobe !== 1'b1 || link_cmd !== 8'h5A) begin
            n_bad++;
            $display("FAIL busy_release got g=%b s=%b c=%h want 0100/1/5a", grant, link_cmd_strobe, link_cmd);
        end
        req = '0;
        link_cmd_busy = 1'b1;
        repeat (2) @(negedge clk);
        link_cmd_busy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 4'b0100) begin
            n_bad++;
            $display("FAIL busy_done got %b want 0100", done);
        end
        m_ptr = 3;
        @(negedge clk);
    endtask

    task automatic test_noop();
        req = 4'b0010; req_cmd = '0;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0010 || done !== 4'b0010 || link_cmd_strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL noop got g=%b d=%b s=%b want 0010/0010/0", grant, done, link_cmd_strobe);
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (grant !== '0 || done !== '0) begin
            n_bad++;
            $display("FAIL noop_width got g=%b d=%b want 0", grant, done);
        end
        m_ptr = 2;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit early;
        req = 4'b0001; req_cmd = '0; req_cmd[7:0] = 8'h33;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001 || link_cmd_strobe !== 1'b1) begin
            n_bad++;
            $display("FAIL to_issue got g=%b s=%b want 0001/1", grant, link_cmd_strobe);
        end
        req = '0;
        early = 1'b0;
`ifdef ULPI_CMD_TIMEOUT_EN
        for (int j = 1; j < 17; j++) begin
            @(negedge clk);
            if (done !== '0 || err !== '0) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_bad++;
            $display("FAIL to_early got done before timeout want none");
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 4'b0001 || err !== 4'b0001) begin
            n_bad++;
            $display("FAIL to_expire got d=%b e=%b want 0001/0001", done, err);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== '0 || err !== '0) begin
            n_bad++;
            $display("FAIL to_width got d=%b e=%b want 0", done, err);
        end
`else
        repeat (1000) begin
            @(negedge clk);
            if (done !== '0 || err !== '0) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_bad++;
            $display("FAIL to_wait got done/err without timeout want none");
        end
        link_cmd_busy = 1'b1;
        repeat (2) @(negedge clk);
        link_cmd_busy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 4'b0001 || err !== '0) begin
            n_bad++;
            $display("FAIL to_late_done got d=%b e=%b want 0001/0000", done, err);
        end
        @(negedge clk);
`endif
        m_ptr = 1;
    endtask

    task automatic test_random();
        bit [N-1:0] pend;
        bit [7:0]   pcmd [N];
        int         cool [N];
        bit         idle_p, noop_wait, done_due, was_due, link_act, busy_p;
        bit [N-1:0] req_p, exp_g, exp_d;
        int         cur, dly, hold, pick, grants;
        pend = '0; idle_p = 1'b1; noop_wait = 1'b0; done_due = 1'b0; link_act = 1'b0;
        cur = 0; dly = 0; hold = 0; grants = 0;
        for (int i = 0; i < N; i++) begin pcmd[i] = 8'h00; cool[i] = 0; end
        req = '0; link_cmd_busy = 1'b0; req_p = '0; busy_p = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            exp_g = '0; exp_d = '0; pick = -1;
            if (idle_p && !busy_p && req_p != '0) begin
                for (int k = 0; k < N; k++)
                    if (pick < 0 && req_p[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                exp_g[pick] = 1'b1;
                if (pcmd[pick] == 8'h00) exp_d[pick] = 1'b1;
            end
            if (done_due) exp_d[cur] = 1'b1;
            n_cmp++;
            if (grant !== exp_g || done !== exp_d || err !== '0) begin
                n_bad++;
                $display("FAIL rand_pulses@%0d got g=%b d=%b e=%b want g=%b d=%b e=0000",
                         c, grant, done, err, exp_g, exp_d);
            end
            n_cmp++;
            if (link_cmd_strobe !== (pick >= 0 && pcmd[pick] != 8'h00)) begin
                n_bad++;
                $display("FAIL rand_strobe@%0d got %b", c, link_cmd_strobe);
            end
            if (pick >= 0 && pcmd[pick] != 8'h00) begin
                n_cmp++;
                if (link_cmd !== pcmd[pick]) begin
                    n_bad++;
                    $display("FAIL rand_cmd@%0d got %h want %h", c, link_cmd, pcmd[pick]);
                end
            end
            was_due  = done_due;
            done_due = 1'b0;
            if (pick >= 0) begin
                cur = pick; m_ptr = (pick + 1) % N; pend[pick] = 1'b0; cool[pick] = 2;
                grants++; idle_p = 1'b0;
                if (pcmd[pick] == 8'h00) noop_wait = 1'b1;
                else begin
                    link_act = 1'b1; dly = $urandom_range(0, 2); hold = $urandom_range(2, 4);
                end
            end else if (noop_wait) begin
                noop_wait = 1'b0; idle_p = 1'b1;
            end else if (was_due) begin
                idle_p = 1'b1;
            end
            if (link_act) begin
                if (dly > 0) begin dly--; link_cmd_busy = 1'b0; end
                else if (hold > 0) begin hold--; link_cmd_busy = 1'b1; end
                else begin link_cmd_busy = 1'b0; link_act = 1'b0; done_due = 1'b1; end
            end
            for (int i = 0; i < N; i++) begin
                if (cool[i] > 0) cool[i]--;
                else if (!pend[i] && c < 700 && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pcmd[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                end
            end
            req = pend;
            for (int i = 0; i < N; i++) req_cmd[8*i +: 8] = pcmd[i];
            req_p  = pend;
            busy_p = link_cmd_busy;
        end
        n_cmp++;
        if (pend !== '0 || link_act || grants < 20) begin
            n_bad++;
            $display("FAIL rand_drain got pend=%b link_act=%0d grants=%0d want 0/0/>=20", pend, link_act, grants);
        end
    endtask

    task automatic test_reset_mid();
        bit spurious;
        req = 4'b0010; req_cmd = '0; req_cmd[15:8] = 8'h42;
        @(negedge clk);
        n_cmp++;
        if (grant !== oh(1)) begin
            n_bad++;
            $display("FAIL rst_mid_issue got %b want 0010", grant);
        end
        req = '0;
        link_cmd_busy = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({grant, done, err, link_cmd_strobe} !== '0 || link_cmd !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_mid_async got g=%b d=%b e=%b s=%b c=%h want 0", grant, done, err, link_cmd_strobe, link_cmd);
        end
        link_cmd_busy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        spurious = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== '0 || grant !== '0) spurious = 1'b1;
        end
        n_cmp++;
        if (spurious) begin
            n_bad++;
            $display("FAIL rst_mid_done got pulse after reset want none");
        end
        req = 4'b1001; req_cmd[7:0] = 8'h11; req_cmd[31:24] = 8'h99;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001 || link_cmd !== 8'h11) begin
            n_bad++;
            $display("FAIL rst_mid_ptr got g=%b c=%h want 0001/11", grant, link_cmd);
        end
        req = '0;
        link_cmd_busy = 1'b1;
        repeat (2) @(negedge clk);
        link_cmd_busy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_mid_done2 got %b want 0001", done);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_busy_block();
        test_noop();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
